// File: rtl/karatsuba_pp_gen_30bit_pkg.sv
// karatsuba_pkg: widths and FSM/pass enums for the 30-bit GF(2) Karatsuba partial-product generator
package karatsuba_pkg;
  localparam int N = 30;
  localparam int HALF = N / 2;
  localparam int PPW = 2 * HALF - 1;
  typedef enum logic [2:0] {IDLE, MUL_L, MUL_H, MUL_M, DONE} state_t;
  typedef enum logic [1:0] {P_L, P_H, P_M} pass_t;
endpackage

// File: rtl/karatsuba_pp_gen_30bit_if.sv
// karatsuba_pp_gen_30bit_if: operand/result handshake bus; master drives operands, slave returns pp_lo/pp_mid/pp_hi
import karatsuba_pkg::*;
interface karatsuba_pp_gen_30bit_if;
  logic in_valid;
  logic in_ready;
  logic [N-1:0] A_in;
  logic [N-1:0] B_in;
  logic out_valid;
  logic out_ready;
  logic [PPW-1:0] pp_lo;
  logic [PPW-1:0] pp_mid;
  logic [PPW-1:0] pp_hi;
  modport master (output in_valid, A_in, B_in, out_ready, input in_ready, out_valid, pp_lo, pp_mid, pp_hi);
  modport slave (input in_valid, A_in, B_in, out_ready, output in_ready, out_valid, pp_lo, pp_mid, pp_hi);
endinterface

// File: rtl/karatsuba_pp_gen_30bit_clmul.sv
// clmul_serial_15bit: bit-serial 15x15 carry-less multiply (ports: clk, rst, start clears, en steps, a, b; acc = accumulator including this cycle's step, done = last step of pass); KPP_EARLY_TERM_EN ends a pass once the shifted multiplier is exhausted
import karatsuba_pkg::*;
module clmul_serial_15bit (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            en,
  input  logic [HALF-1:0] a,
  input  logic [HALF-1:0] b,
  output logic [PPW-1:0]  acc,
  output logic            done
);
  logic [PPW-1:0] acc_q;
  logic [3:0] cnt;
  logic bit_c;
`ifdef KPP_EARLY_TERM_EN
  logic [HALF-1:0] bw, cur;
  // first cycle of a pass reads b directly; later cycles read the shifted copy
  assign cur = cnt == 4'd0 ? b : bw;
  assign bit_c = cur[0];
  assign done = en && cur[HALF-1:1] == '0;
  always_ff @(posedge clk)
    if (rst || start || done) bw <= '0;
    else if (en) bw <= cur >> 1;
`else
  assign bit_c = b[cnt];
  assign done = en && cnt == 4'(HALF - 1);
`endif
  assign acc = bit_c ? acc_q ^ ({{(PPW-HALF){1'b0}}, a} << cnt) : acc_q;
  always_ff @(posedge clk) begin
    if (rst || start || done) begin
      acc_q <= '0;
      cnt <= '0;
    end else if (en) begin
      acc_q <= acc;
      cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: rtl/karatsuba_pp_gen_30bit.sv
// karatsuba_pp_gen_30bit: three-pass sequential GF(2) Karatsuba partial products (ports: clk, rst, bus = slave handshake with A_in/B_in in, pp_lo/pp_mid/pp_hi out); optional KPP_EARLY_TERM_EN shortens passes
import karatsuba_pkg::*;
module karatsuba_pp_gen_30bit (
  input logic clk,
  input logic rst,
  karatsuba_pp_gen_30bit_if.slave bus
);
  state_t state, state_n;
  pass_t sel;
  logic [N-1:0] a_q, b_q;
  logic [HALF-1:0] a_op, b_op;
  logic [PPW-1:0] acc, lo_q, mid_q, hi_q;
  logic done, busy, start;
  assign start = state == IDLE && bus.in_valid;
  assign busy = state inside {MUL_L, MUL_H, MUL_M};
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.pp_lo = lo_q;
  assign bus.pp_mid = mid_q;
  assign bus.pp_hi = hi_q;
  assign sel = state == MUL_H ? P_H : state == MUL_M ? P_M : P_L;
  assign a_op = sel == P_L ? a_q[HALF-1:0] : sel == P_H ? a_q[N-1:HALF] : a_q[HALF-1:0] ^ a_q[N-1:HALF];
  assign b_op = sel == P_L ? b_q[HALF-1:0] : sel == P_H ? b_q[N-1:HALF] : b_q[HALF-1:0] ^ b_q[N-1:HALF];
  clmul_serial_15bit u_mul (
    .clk(clk),
    .rst(rst),
    .start(start),
    .en(busy),
    .a(a_op),
    .b(b_op),
    .acc(acc),
    .done(done)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.in_valid ? MUL_L : IDLE;
      MUL_L: state_n = done ? MUL_H : MUL_L;
      MUL_H: state_n = done ? MUL_M : MUL_H;
      MUL_M: state_n = done ? DONE : MUL_M;
      DONE: state_n = bus.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      lo_q <= '0;
      mid_q <= '0;
      hi_q <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        a_q <= bus.A_in;
        b_q <= bus.B_in;
      end
      if (done && state == MUL_L) lo_q <= acc;
      if (done && state == MUL_H) hi_q <= acc;
      // middle term is corrected by removing both outer products
      if (done && state == MUL_M) mid_q <= acc ^ lo_q ^ hi_q;
    end
  end
endmodule

// File: tb/tb_karatsuba_pp_gen_30bit.sv
// tb_karatsuba_pp_gen_30bit: randomized scoreboard bench against a software carry-less model
import karatsuba_pkg::*;
module tb_karatsuba_pp_gen_30bit;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [28:0] lo, mid, hi;} exp_t;
  exp_t sb[$];
  int hs = 0;
  bit seen = 0;
  karatsuba_pp_gen_30bit_if bus ();
  karatsuba_pp_gen_30bit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [28:0] clmul(input logic [14:0] a, input logic [14:0] b);
    logic [28:0] r = '0;
    for (int i = 0; i < 15; i++)
      if (b[i]) r ^= 29'(a) << i;
    return r;
  endfunction
  function automatic exp_t model(input logic [29:0] a, input logic [29:0] b);
    exp_t e;
    e.lo = clmul(a[14:0], b[14:0]);
    e.hi = clmul(a[29:15], b[29:15]);
    e.mid = clmul(a[14:0] ^ a[29:15], b[14:0] ^ b[29:15]) ^ e.lo ^ e.hi;
    return e;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      seen = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) hs = cyc;
      if (bus.out_valid) begin
        if (!seen) begin
          seen = 1;
`ifdef KPP_EARLY_TERM_EN
          chk("latency_max", 64'(cyc - hs <= 46), 64'd1);
`else
          chk("latency", 64'(cyc - hs), 64'd46);
`endif
        end
        chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
        if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
        else begin
          chk("pp_lo", 64'(bus.pp_lo), 64'(sb[0].lo));
          chk("pp_mid", 64'(bus.pp_mid), 64'(sb[0].mid));
          chk("pp_hi", 64'(bus.pp_hi), 64'(sb[0].hi));
          if (bus.out_ready) begin
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_job(input logic [29:0] a, input logic [29:0] b);
    int t = 0;
    bus.in_valid = 0;
    while (!bus.in_ready && t < 200) begin tick(); t++; end
    if (!bus.in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    bus.A_in = a;
    bus.B_in = b;
    bus.in_valid = 1;
    @(posedge clk);
    sb.push_back(model(a, b));
    #1;
    bus.in_valid = 0;
  endtask
  task automatic finish_job(input int hold, input bit noise);
    int t = 0;
    while (!bus.out_valid && t < 100) begin
      if (noise) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.A_in = 30'($urandom);
        bus.B_in = 30'($urandom);
      end
      tick();
      t++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.A_in = 30'($urandom);
      tick();
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
  endtask
  initial begin
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.A_in = '0;
    bus.B_in = '0;
    repeat (3) tick();
    rst = 0;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_pp", 64'({bus.pp_lo, bus.pp_mid} | 58'(bus.pp_hi)), 64'd0);
    start_job(30'h1, 30'h1);
    finish_job(0, 0);
    start_job(30'h3FFFFFFF, 30'h3FFFFFFF);
    finish_job(1, 0);
    start_job(30'h8001, 30'h8001);
    finish_job(0, 0);
    chk("overlap_product", 64'(59'(bus.pp_lo) ^ (59'(bus.pp_mid) << 15) ^ (59'(bus.pp_hi) << 30)), 64'h40000001);
    start_job(30'h2ABCDEF1, 30'h15A5A5A5);
    finish_job(20, 1);
`ifdef KPP_EARLY_TERM_EN
    start_job(30'h12345678, 30'h0);
    while (!bus.out_valid && cyc < 1000000) tick();
    chk("early_b0_latency", 64'(cyc - hs), 64'd4);
    finish_job(0, 0);
`else
    start_job(30'h12345678, 30'h0);
    finish_job(0, 0);
`endif
    start_job(30'h1FFF7FFF, 30'h3FFF7FFF);
    repeat (19) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_pp", 64'({bus.pp_lo, bus.pp_mid} | 58'(bus.pp_hi)), 64'd0);
    start_job(30'h0ABCDE12, 30'h3A5B6C7D);
    finish_job(0, 0);
    for (int k = 0; k < 1000; k++) begin
      start_job(30'($urandom), 30'($urandom));
      finish_job(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
